// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// Module : hazard_ctrl_pkg
// Brief  : MIPS opcode/funct constants, Tuse/Tnew constants, shadow record.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_MFHI    = 6'b010000;
    localparam logic [5:0] FN_MTHI    = 6'b010001;
    localparam logic [5:0] FN_MFLO    = 6'b010010;
    localparam logic [5:0] FN_MTLO    = 6'b010011;
    localparam logic [5:0] FN_MULT    = 6'b011000;
    localparam logic [5:0] FN_MULTU   = 6'b011001;
    localparam logic [5:0] FN_DIV     = 6'b011010;
    localparam logic [5:0] FN_DIVU    = 6'b011011;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUB     = 6'b100010;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_XOR     = 6'b100110;
    localparam logic [5:0] FN_NOR     = 6'b100111;
    localparam logic [5:0] FN_SLT     = 6'b101010;
    localparam logic [5:0] FN_SLTU    = 6'b101011;

    localparam logic [1:0] TUSE_0     = 2'd0;
    localparam logic [1:0] TUSE_1     = 2'd1;
    localparam logic [1:0] TUSE_2     = 2'd2;
    localparam logic [1:0] TUSE_NONE  = 2'd3;

    localparam logic [1:0] TNEW_0     = 2'd0;
    localparam logic [1:0] TNEW_ALU   = 2'd1;
    localparam logic [1:0] TNEW_LW    = 2'd2;

    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       md;
    } shadow_t;

    localparam shadow_t SHADOW_BUBBLE = '{dst: 5'd0, tnew: TNEW_0, md: 1'b0};

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_decode.sv
// ============================================================================
// Module : hazard_decode
// Brief  : Combinational IR -> {dst, Tnew, Tuse_rs, Tuse_rt, md, mdu_op}.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_decode
    import hazard_ctrl_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [4:0]  rs_o,
    output logic [4:0]  rt_o,
    output logic [4:0]  dst_o,
    output logic [1:0]  tnew_o,
    output logic [1:0]  tuse_rs_o,
    output logic [1:0]  tuse_rt_o,
    output logic        md_o,
    output logic        md_div_o,
    output logic        mdu_op_o
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rd;
    logic       is_r, cal_r, cal_i, is_mfx, is_mtx, is_mul, is_div, is_br;
    logic       unused_shamt;

    assign op           = ir_i[31:26];
    assign fn           = ir_i[5:0];
    assign rs_o         = ir_i[25:21];
    assign rt_o         = ir_i[20:16];
    assign rd           = ir_i[15:11];
    assign unused_shamt = ^ir_i[10:6];

    assign is_r   = (op == OP_SPECIAL);
    // jr shares the special opcode but is deliberately excluded from cal_r
    assign cal_r  = is_r && (fn == FN_ADD || fn == FN_ADDU || fn == FN_SUB  || fn == FN_SUBU ||
                             fn == FN_AND || fn == FN_OR   || fn == FN_XOR  || fn == FN_NOR  ||
                             fn == FN_SLT || fn == FN_SLTU);
    assign cal_i  = (op == OP_ORI) || (op == OP_LUI) || (op == OP_ADDI) || (op == OP_ADDIU);
    assign is_mfx = is_r && (fn == FN_MFHI || fn == FN_MFLO);
    assign is_mtx = is_r && (fn == FN_MTHI || fn == FN_MTLO);
    assign is_mul = is_r && (fn == FN_MULT || fn == FN_MULTU);
    assign is_div = is_r && (fn == FN_DIV  || fn == FN_DIVU);
    assign is_br  = (op == OP_BEQ) || (op == OP_BNE);

    assign md_o     = is_mul || is_div;
    assign md_div_o = is_div;
    assign mdu_op_o = is_mul || is_div || is_mfx || is_mtx;

    always_comb begin
        dst_o     = 5'd0;
        tnew_o    = TNEW_0;
        tuse_rs_o = TUSE_NONE;
        tuse_rt_o = TUSE_NONE;

        if (cal_r || is_mfx) begin
            dst_o  = rd;
            tnew_o = TNEW_ALU;
        end else if (cal_i) begin
            dst_o  = rt_o;
            tnew_o = TNEW_ALU;
        end else if (op == OP_LW) begin
            dst_o  = rt_o;
            tnew_o = TNEW_LW;
        end else if (op == OP_JAL) begin
            dst_o  = 5'd31;
            tnew_o = TNEW_0;
        end

        if (is_br || (is_r && fn == FN_JR))
            tuse_rs_o = TUSE_0;
        else if (cal_r || cal_i || op == OP_LW || op == OP_SW || is_mul || is_div)
            tuse_rs_o = TUSE_1;

        if (is_br)
            tuse_rt_o = TUSE_0;
        else if (cal_r || is_mul || is_div)
            tuse_rt_o = TUSE_1;
        else if (op == OP_SW)
            tuse_rt_o = TUSE_2;
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module : hazard_ctrl
// Brief  : D-stage stall unit (Tuse/Tnew) with E/M shadows and MDU busy tracker.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IR_D,
    output logic             stall,
    output logic             flush_E,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int MC_W = $clog2(DIV_LAT + 1);

    logic [4:0] rs_w, rt_w, dst_w;
    logic [1:0] tnew_w, tuse_rs_w, tuse_rt_w;
    logic       md_w, md_div_w, mdu_op_w;

    hazard_decode u_decode (
        .ir_i      (IR_D),
        .rs_o      (rs_w),
        .rt_o      (rt_w),
        .dst_o     (dst_w),
        .tnew_o    (tnew_w),
        .tuse_rs_o (tuse_rs_w),
        .tuse_rt_o (tuse_rt_w),
        .md_o      (md_w),
        .md_div_o  (md_div_w),
        .mdu_op_o  (mdu_op_w)
    );

    shadow_t           e_q, e_d, m_q, m_d;
    logic              e_div_q, e_div_d;
    logic [MC_W-1:0]   mdu_cnt_q, mdu_cnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic              busy_raw, data_stall, stall_raw;

    function automatic logic hit(input logic [4:0] src, input logic [1:0] tuse,
                                 input shadow_t s);
        return (src != 5'd0) && (src == s.dst) && (tuse < s.tnew);
    endfunction

    assign busy_raw   = e_q.md || (mdu_cnt_q != '0);
    assign data_stall = hit(rs_w, tuse_rs_w, e_q) || hit(rt_w, tuse_rt_w, e_q) ||
                        hit(rs_w, tuse_rs_w, m_q) || hit(rt_w, tuse_rt_w, m_q);
    assign stall_raw  = data_stall || (mdu_op_w && busy_raw);

    // Outputs are forced low during reset so a hazard on IR_D cannot leak out
    assign stall       = stall_raw && !reset;
    assign flush_E     = stall;
    assign mdu_busy    = busy_raw && !reset;
    assign stall_count = stall_count_q;

    always_comb begin
        e_d     = SHADOW_BUBBLE;
        e_div_d = 1'b0;
        if (!stall) begin
            e_d     = '{dst: dst_w, tnew: tnew_w, md: md_w};
            e_div_d = md_div_w;
        end

        m_d      = e_q;
        m_d.tnew = (e_q.tnew == TNEW_0) ? TNEW_0 : (e_q.tnew - 2'd1);

        mdu_cnt_d = mdu_cnt_q;
        if (e_q.md)
            mdu_cnt_d = e_div_q ? MC_W'(DIV_LAT) : MC_W'(MULT_LAT);
        else if (mdu_cnt_q != '0)
            mdu_cnt_d = mdu_cnt_q - 1'b1;

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1))
            stall_count_d = stall_count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q           <= SHADOW_BUBBLE;
            e_div_q       <= 1'b0;
            m_q           <= SHADOW_BUBBLE;
            mdu_cnt_q     <= '0;
            stall_count_q <= '0;
        end else begin
            e_q           <= e_d;
            e_div_q       <= e_div_d;
            m_q           <= m_d;
            mdu_cnt_q     <= mdu_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module : tb_hazard_ctrl
// Brief  : Scoreboard bench for hazard_ctrl driven by directed instruction streams.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] LW1      = 32'h8C01_0000; // lw   $1,0($0)
    localparam logic [31:0] ADD231   = 32'h0023_1020; // add  $2,$1,$3
    localparam logic [31:0] ADDU1    = 32'h0043_0821; // addu $1,$2,$3
    localparam logic [31:0] BEQ12    = 32'h1022_0000; // beq  $1,$2
    localparam logic [31:0] SW12     = 32'hAC41_0000; // sw   $1,0($2)
    localparam logic [31:0] MULT45   = 32'h0085_0018; // mult $4,$5
    localparam logic [31:0] MFLO6    = 32'h0000_3012; // mflo $6
    localparam logic [31:0] ADDU0    = 32'h0022_0021; // addu $0,$1,$2
    localparam logic [31:0] BEQ00    = 32'h1000_0000; // beq  $0,$0
    localparam logic [31:0] JAL      = 32'h0C00_0000;
    localparam logic [31:0] JR31     = 32'h03E0_0008;
    localparam logic [31:0] DIV45    = 32'h0085_001A; // div  $4,$5
    localparam logic [31:0] MFHI7    = 32'h0000_3810; // mfhi $7

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IR_D = 32'h0;
    logic        stall, flush_E, mdu_busy;
    logic [3:0]  stall_count;

    typedef struct {
        logic s;
        logic b;
        int   c;   // -1: stall_count not checked this cycle
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    hazard_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .IR_D        (IR_D),
        .stall       (stall),
        .flush_E     (flush_E),
        .mdu_busy    (mdu_busy),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [31:0] ir,
                        input logic es, input logic eb, input int ec);
        @(posedge clk);
        #1;
        reset = r;
        IR_D  = ir;
        q.push_back('{s: es, b: eb, c: ec});
    endtask

    always @(negedge clk) begin
        cyc++;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (stall !== e.s) begin
                errors++;
                $display("FAIL stall cyc=%0d ir=%h got %b exp %b", cyc, IR_D, stall, e.s);
            end
            checks++;
            if (flush_E !== e.s) begin
                errors++;
                $display("FAIL flush_E cyc=%0d ir=%h got %b exp %b", cyc, IR_D, flush_E, e.s);
            end
            checks++;
            if (mdu_busy !== e.b) begin
                errors++;
                $display("FAIL mdu_busy cyc=%0d ir=%h got %b exp %b", cyc, IR_D, mdu_busy, e.b);
            end
            if (e.c >= 0) begin
                checks++;
                if (stall_count !== 4'(e.c)) begin
                    errors++;
                    $display("FAIL stall_count cyc=%0d got %0d exp %0d", cyc, stall_count, e.c);
                end
            end
        end
    end

    initial begin
        int cnt;

        // lw then dependent add: one stall
        step(1, NOP,    0, 0, -1);
        step(0, LW1,    0, 0, 0);
        step(0, ADD231, 1, 0, 0);
        step(0, ADD231, 0, 0, 1);
        step(0, NOP,    0, 0, 1);

        // addu then beq: one stall
        step(1, NOP,    0, 0, -1);
        step(0, ADDU1,  0, 0, 0);
        step(0, BEQ12,  1, 0, 0);
        step(0, BEQ12,  0, 0, 1);
        step(0, NOP,    0, 0, 1);

        // lw then beq: two stalls
        step(1, NOP,    0, 0, -1);
        step(0, LW1,    0, 0, 0);
        step(0, BEQ12,  1, 0, 0);
        step(0, BEQ12,  1, 0, 1);
        step(0, BEQ12,  0, 0, 2);
        step(0, NOP,    0, 0, 2);

        // lw then sw storing the loaded reg: no stall
        step(1, NOP,    0, 0, -1);
        step(0, LW1,    0, 0, 0);
        step(0, SW12,   0, 0, 0);
        step(0, NOP,    0, 0, 0);

        // mult then mflo: six stalls, busy drops afterwards
        step(1, NOP,    0, 0, -1);
        step(0, MULT45, 0, 0, 0);
        for (int k = 0; k < 6; k++) step(0, MFLO6, 1, 1, k);
        step(0, MFLO6,  0, 0, 6);
        step(0, NOP,    0, 0, 6);

        // $0 destination and jal/jr: no stall
        step(1, NOP,    0, 0, -1);
        step(0, ADDU0,  0, 0, 0);
        step(0, BEQ00,  0, 0, 0);
        step(0, JAL,    0, 0, 0);
        step(0, JR31,   0, 0, 0);
        step(0, NOP,    0, 0, 0);

        // div in flight, reset at count 7 with mfhi waiting in D
        step(1, NOP,    0, 0, -1);
        step(0, DIV45,  0, 0, 0);
        step(0, NOP,    0, 1, 0);   // div in E
        step(0, NOP,    0, 1, 0);   // count 10
        step(0, NOP,    0, 1, 0);   // 9
        step(0, NOP,    0, 1, 0);   // 8
        step(1, MFHI7,  0, 0, 0);   // count 7, reset asserted
        step(0, MFHI7,  0, 0, 0);
        step(0, NOP,    0, 0, 0);

        // saturation of the 4-bit stall counter
        step(1, NOP,    0, 0, -1);
        cnt = 0;
        for (int r = 0; r < 3; r++) begin
            step(0, MULT45, 0, 0, cnt);
            for (int k = 0; k < 6; k++) begin
                step(0, MFLO6, 1, 1, cnt);
                cnt = (cnt < 15) ? cnt + 1 : 15;
            end
            step(0, MFLO6, 0, 0, cnt);
        end
        step(0, NOP, 0, 0, 15);
        step(0, NOP, 0, 0, 15);

        repeat (2) @(posedge clk);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
